// File: rtl/fetch_pkg.sv
// Shared widths and state encodings for the fetch sequencer.
package fetch_pkg;
  localparam int XLEN_D    = 32;
  localparam int ILEN_D    = 32;
  localparam int MAX_OUT_D = 4;

  typedef enum logic {RUN, FLUSH} state_t;

  // Ordered so that a numerically larger value wins arbitration.
  typedef enum logic [1:0] {NONE = 2'd0, BRANCH = 2'd1, TRAP = 2'd2} redir_pri_t;
endpackage

// File: rtl/fetch_im_if.sv
// Instruction-memory read bus: AR request channel plus in-order R response channel.
interface fetch_im_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [ILEN-1:0] rdata;

  modport master (output arvalid, araddr, rready, input arready, rvalid, rdata);
  modport slave  (input arvalid, araddr, rready, output arready, rvalid, rdata);
endinterface

// File: rtl/fetch_pc_fifo.sv
// PC FIFO pairing in-flight reads with their addresses; flush empties it in one cycle.
module fetch_pc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wptr <= r_wptr + 1'b1;
      if (i_pop  && !o_empty) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues I-mem reads at the counter PC, pairs responses with PCs,
// applies trap/branch redirects through the counter's load-offset port and drops stale data.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int ILEN    = ILEN_D,
  parameter int MAX_OUT = MAX_OUT_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pc_tvalid,
  output logic            o_pc_tready,
  input  logic [XLEN-1:0] i_pc_tdata,
  output logic            o_pc_load_en,
  output logic [XLEN-1:0] o_pc_load_data,
  fetch_im_if.master      im,
  output logic            o_inst_tvalid,
  input  logic            i_inst_tready,
  output logic [ILEN-1:0] o_inst_tdata,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_target,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_stall
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_out, r_drop, w_out_nx, w_drop_nx;
  redir_pri_t      r_pend_pri, w_new_pri, w_pend_pri;
  logic [XLEN-1:0] r_pend_tgt, w_new_tgt, w_pend_tgt, r_araddr, w_fifo_head;
  logic            r_ar_hold;
  logic            w_issue, w_acc, w_rsp, w_apply, w_dropping, w_deliver;
  logic            w_fifo_full, w_fifo_empty;

  // Trap beats branch; a pending redirect only yields to equal or higher priority.
  always_comb begin
    w_new_pri  = NONE;
    w_new_tgt  = i_br_target;
    if (i_trap_valid) begin
      w_new_pri = TRAP;
      w_new_tgt = i_trap_target;
    end else if (i_br_valid) begin
      w_new_pri = BRANCH;
    end
    w_pend_pri = r_pend_pri;
    w_pend_tgt = r_pend_tgt;
    if (w_new_pri != NONE && w_new_pri >= r_pend_pri) begin
      w_pend_pri = w_new_pri;
      w_pend_tgt = w_new_tgt;
    end
  end

  assign w_dropping = (r_drop != '0);
  assign w_issue    = !rst && r_state == RUN && i_pc_tvalid && !i_stall &&
                      r_out < MAX_CNT && !w_fifo_full &&
                      w_new_pri == NONE && r_pend_pri == NONE;

  assign im.arvalid = !rst && (r_ar_hold || w_issue);
  assign im.araddr  = r_ar_hold ? r_araddr : i_pc_tdata;
  assign w_acc      = im.arvalid && im.arready;

  // A held request must be accepted before the counter may be reloaded.
  assign w_apply        = !rst && w_pend_pri != NONE && !(r_ar_hold && !im.arready);
  assign o_pc_tready    = w_acc || w_apply;
  assign o_pc_load_en   = w_apply;
  assign o_pc_load_data = w_pend_tgt - i_pc_tdata;

  assign im.rready     = !rst && (w_dropping || i_inst_tready);
  assign o_inst_tvalid = !rst && !w_dropping && im.rvalid;
  assign o_inst_tdata  = im.rdata;
  assign o_inst_pc     = w_fifo_head;
  assign w_rsp         = im.rvalid && im.rready;
  assign w_deliver     = o_inst_tvalid && i_inst_tready && !w_fifo_empty;

  assign w_out_nx  = r_out + CW'(w_acc) - CW'(w_rsp);
  assign w_drop_nx = w_apply ? w_out_nx : r_drop - CW'(w_dropping && w_rsp);

  always_comb begin
    w_state_nx = r_state;
    if (w_apply)
      w_state_nx = (w_out_nx != '0) ? FLUSH : RUN;
    else if (r_state == FLUSH && w_drop_nx == '0)
      w_state_nx = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_drop     <= '0;
      r_pend_pri <= NONE;
      r_pend_tgt <= '0;
      r_ar_hold  <= 1'b0;
      r_araddr   <= '0;
    end else begin
      r_out      <= w_out_nx;
      r_drop     <= w_drop_nx;
      r_pend_pri <= w_apply ? NONE : w_pend_pri;
      r_pend_tgt <= w_pend_tgt;
      r_ar_hold  <= im.arvalid && !im.arready;
      if (im.arvalid) r_araddr <= im.araddr;
    end
  end

  fetch_pc_fifo #(.DEPTH(MAX_OUT), .W(XLEN)) u_pc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_acc),
    .i_pop   (w_deliver),
    .i_flush (w_apply),
    .i_data  (im.araddr),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  a_rsp_with_outstanding: assert property (@(posedge clk) disable iff (rst) w_rsp |-> r_out != '0);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed redirect/stall scenarios against a PC-counter
// and in-order memory model, with expected AR/load/instruction queues scoreboarded.
module tb_fetch_sequencer;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_tvalid, pc_tready, pc_load_en;
  logic [31:0] pc, pc_load_data;
  logic        inst_tvalid, inst_tready;
  logic [31:0] inst_tdata, inst_pc;
  logic        trap_v, br_v, stall;
  logic [31:0] trap_t, br_t;

  always #5 clk = ~clk;

  fetch_im_if #(.XLEN(32), .ILEN(32)) im ();

  fetch_sequencer #(.XLEN(32), .ILEN(32), .MAX_OUT(MAXO)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pc_tvalid    (pc_tvalid),
    .o_pc_tready    (pc_tready),
    .i_pc_tdata     (pc),
    .o_pc_load_en   (pc_load_en),
    .o_pc_load_data (pc_load_data),
    .im             (im),
    .o_inst_tvalid  (inst_tvalid),
    .i_inst_tready  (inst_tready),
    .o_inst_tdata   (inst_tdata),
    .o_inst_pc      (inst_pc),
    .i_trap_valid   (trap_v),
    .i_trap_target  (trap_t),
    .i_br_valid     (br_v),
    .i_br_target    (br_t),
    .i_stall        (stall)
  );

  int checks = 0, errors = 0;
  int acc_cnt = 0, drop_cnt = 0, tb_out = 0, cyc = 0;
  logic [31:0] exp_ar[$], exp_pc[$], exp_ld[$];
  logic mem_hold = 1'b0;

  typedef struct { logic [31:0] a; int rdy; } mreq_t;
  mreq_t mq[$];

  logic        f_acc, f_rsp, f_tr, f_ld;
  logic [31:0] f_addr, f_ldd;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected %h with nothing expected", nm, act);
  endtask

  // Monitor at negedge, then PC-counter and memory models advance just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      f_acc  = im.arvalid && im.arready;
      f_rsp  = im.rvalid && im.rready;
      f_tr   = pc_tready;
      f_ld   = pc_load_en;
      f_addr = im.araddr;
      f_ldd  = pc_load_data;
      if (!rst) begin
        if (f_acc) begin
          chk("outstanding_cap", 32'(tb_out < MAXO), 32'd1);
          if (exp_ar.size() == 0) unexp("araddr", f_addr);
          else chk("araddr", f_addr, exp_ar.pop_front());
          acc_cnt++;
        end
        if (f_tr || f_acc || f_ld) chk("pc_tready", 32'(f_tr), 32'(f_acc || f_ld));
        if (f_ld) begin
          if (exp_ld.size() == 0) unexp("load_data", f_ldd);
          else chk("load_data", f_ldd, exp_ld.pop_front());
        end
        if (inst_tvalid && inst_tready) begin
          if (exp_pc.size() == 0) unexp("inst_pc", inst_pc);
          else begin
            logic [31:0] e;
            e = exp_pc.pop_front();
            chk("inst_pc", inst_pc, e);
            chk("inst_data", inst_tdata, memf(e));
          end
        end
        if (f_rsp && !inst_tvalid) drop_cnt++;
        tb_out = tb_out + int'(f_acc) - int'(f_rsp);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        mq.delete();
        tb_out = 0;
      end else begin
        if (f_tr) pc = f_ld ? pc + f_ldd : pc + 32'd4;
        if (f_rsp && mq.size() > 0) void'(mq.pop_front());
        if (f_acc) mq.push_back('{f_addr, cyc + 2});
      end
      im.rvalid = !mem_hold && mq.size() > 0 && mq[0].rdy <= cyc;
      im.rdata  = (mq.size() > 0) ? memf(mq[0].a) : 32'h0;
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rst = 1'b1; pc = pc0; pc_tvalid = 1'b1; stall = 1'b0;
    trap_v = 1'b0; br_v = 1'b0; trap_t = '0; br_t = '0;
    inst_tready = 1'b1; im.arready = 1'b1; mem_hold = 1'b0;
    cyc1(); cyc1();
    #1;
    chk("rst_arvalid",  32'(im.arvalid),   32'd0);
    chk("rst_tready",   32'(pc_tready),    32'd0);
    chk("rst_load_en",  32'(pc_load_en),   32'd0);
    chk("rst_tvalid",   32'(inst_tvalid),  32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string nm);
    int k = 0;
    while (acc_cnt < n && k < 200) begin cyc1(); k++; end
    chk(nm, 32'(acc_cnt), 32'(n));
  endtask

  task automatic wait_drop(input int n, input string nm);
    int k = 0;
    while (drop_cnt < n && k < 200) begin cyc1(); k++; end
    chk(nm, 32'(drop_cnt), 32'(n));
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((exp_pc.size() != 0 || tb_out != 0) && k < 300) begin cyc1(); k++; end
    chk({nm, "_pc_left"}, 32'(exp_pc.size()), 32'd0);
    chk({nm, "_ar_left"}, 32'(exp_ar.size()), 32'd0);
    chk({nm, "_ld_left"}, 32'(exp_ld.size()), 32'd0);
  endtask

  initial begin
    int base, dbase;
    pc = '0; pc_tvalid = 1'b0; stall = 1'b1; trap_v = 1'b0; br_v = 1'b0;
    trap_t = '0; br_t = '0; inst_tready = 1'b0;
    im.arready = 1'b0; im.rvalid = 1'b0; im.rdata = '0;

    // 1: streaming from 0, saturation at MAX_OUT while memory withholds data
    do_reset(32'h0);
    mem_hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_ar.push_back(32'(4 * i));
      exp_pc.push_back(32'(4 * i));
    end
    base = acc_cnt;
    for (int i = 0; i < 4; i++) cyc1();
    chk("t1_b2b_issue", 32'(acc_cnt - base), 32'd4);
    cyc1(); cyc1();
    #1;
    chk("t1_sat_arvalid", 32'(im.arvalid), 32'd0);
    chk("t1_sat_count", 32'(acc_cnt - base), 32'd4);
    mem_hold = 1'b0;
    wait_acc(base + 12, "t1_issue");
    stall = 1'b1;
    wait_drain("t1");

    // 2: branch to 0x100 with 3 outstanding at PC 0x0C
    do_reset(32'h0);
    mem_hold = 1'b1;
    base = acc_cnt;
    exp_ar.push_back(32'h0); exp_ar.push_back(32'h4); exp_ar.push_back(32'h8);
    exp_ar.push_back(32'h100); exp_ar.push_back(32'h104);
    exp_ld.push_back(32'hF4);
    exp_pc.push_back(32'h100); exp_pc.push_back(32'h104);
    wait_acc(base + 3, "t2_fill");
    stall = 1'b1; br_v = 1'b1; br_t = 32'h100;
    dbase = drop_cnt;
    cyc1();
    br_v = 1'b0; mem_hold = 1'b0;
    wait_drop(dbase + 3, "t2_dropped");
    stall = 1'b0;
    wait_acc(base + 5, "t2_issue");
    stall = 1'b1;
    wait_drain("t2");

    // 3: simultaneous trap and branch, trap wins
    do_reset(32'h40);
    stall = 1'b1;
    exp_ld.push_back(32'h40);
    exp_ar.push_back(32'h80); exp_ar.push_back(32'h84);
    exp_pc.push_back(32'h80); exp_pc.push_back(32'h84);
    trap_v = 1'b1; trap_t = 32'h80; br_v = 1'b1; br_t = 32'h200;
    cyc1();
    trap_v = 1'b0; br_v = 1'b0; stall = 1'b0;
    base = acc_cnt;
    wait_acc(base + 2, "t3_issue");
    stall = 1'b1;
    wait_drain("t3");

    // 4: redirect while a request is held by arready=0
    do_reset(32'h20);
    im.arready = 1'b0;
    base = acc_cnt; dbase = drop_cnt;
    exp_ar.push_back(32'h20); exp_ar.push_back(32'h300); exp_ar.push_back(32'h304);
    exp_ld.push_back(32'h2E0);
    exp_pc.push_back(32'h300); exp_pc.push_back(32'h304);
    #1;
    chk("t4_arvalid_a", 32'(im.arvalid), 32'd1);
    chk("t4_araddr_a", im.araddr, 32'h20);
    cyc1();
    br_v = 1'b1; br_t = 32'h300;
    #1;
    chk("t4_arvalid_b", 32'(im.arvalid), 32'd1);
    chk("t4_araddr_b", im.araddr, 32'h20);
    chk("t4_no_early_load", 32'(pc_load_en), 32'd0);
    cyc1();
    br_v = 1'b0; im.arready = 1'b1;
    #1;
    chk("t4_load_on_accept", 32'(pc_load_en), 32'd1);
    chk("t4_araddr_c", im.araddr, 32'h20);
    wait_drop(dbase + 1, "t4_dropped");
    wait_acc(base + 3, "t4_issue");
    stall = 1'b1;
    wait_drain("t4");

    // 5: offset wraps modulo 2^32
    do_reset(32'hFFFF_FFF8);
    stall = 1'b1;
    exp_ld.push_back(32'h0000_000C);
    exp_ar.push_back(32'h4); exp_ar.push_back(32'h8);
    exp_pc.push_back(32'h4); exp_pc.push_back(32'h8);
    br_v = 1'b1; br_t = 32'h4;
    cyc1();
    br_v = 1'b0; stall = 1'b0;
    base = acc_cnt;
    wait_acc(base + 2, "t5_issue");
    stall = 1'b1;
    wait_drain("t5");

    // 6: decode back-pressure, then stall blocking and release
    do_reset(32'h500);
    inst_tready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_ar.push_back(32'h500 + 32'(4 * i));
      exp_pc.push_back(32'h500 + 32'(4 * i));
    end
    wait_acc(base + 3, "t6_fill");
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc1();
      #1;
      chk("t6_rready_hold", 32'(im.rready), 32'd0);
    end
    chk("t6_tvalid_pending", 32'(inst_tvalid), 32'd1);
    inst_tready = 1'b1;
    wait_drain("t6");
    #1;
    chk("t6_stall_blocks", 32'(im.arvalid), 32'd0);
    exp_ar.push_back(32'h50C); exp_pc.push_back(32'h50C);
    base = acc_cnt;
    stall = 1'b0;
    #1;
    chk("t6_resume_arvalid", 32'(im.arvalid), 32'd1);
    chk("t6_resume_araddr", im.araddr, 32'h50C);
    wait_acc(base + 1, "t6_resume_issue");
    stall = 1'b1;
    wait_drain("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
